// File: rtl/music_pkg.sv
`default_nettype none
// ============================================================================
// Module      : music_pkg
// Description : Shared types and the note half-period table for the
//               sequencer and the PWM tone generator (40 MHz clock).
// Revision    : 1.0 - initial release
// ============================================================================
package music_pkg;

    typedef logic [3:0] note_code_t;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        PLAY = 3'd2,
        GAP  = 3'd3,
        DONE = 3'd4
    } seq_state_t;

    localparam note_code_t NOTE_REST = 4'h0;
    localparam note_code_t NOTE_END  = 4'hF;

    // Chromatic C4..C#5; values above 16 bits saturate at 65535.
    localparam logic [15:0] HP_TABLE [0:15] = '{
        16'd0,     16'd65535, 16'd65535, 16'd65535,
        16'd64282, 16'd60674, 16'd57269, 16'd54054,
        16'd51021, 16'd48157, 16'd45454, 16'd42903,
        16'd40495, 16'd38222, 16'd36077, 16'd0
    };

endpackage
`default_nettype wire

// File: rtl/tick_timer.sv
`default_nettype none
// ============================================================================
// Module      : tick_timer
// Description : Restartable interval timer; expire pulses on the last cycle
//               of a limit-cycle interval whose first cycle is the start pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module tick_timer #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             nreset,
    input  logic             start,
    input  logic [CNT_W-1:0] limit,
    output logic             expire
);

    logic [CNT_W-1:0] r_cnt;
    logic             r_run;
    logic             w_short;
    logic             w_last;

    assign w_short = (limit <= CNT_W'(1));
    assign w_last  = (r_cnt == limit - CNT_W'(1));
    assign expire  = start ? w_short : (r_run && w_last);

    always_ff @(posedge clk or posedge nreset) begin
        if (nreset) begin
            r_cnt <= '0;
            r_run <= 1'b0;
        end else if (start) begin
            // The start cycle itself is tick 0.
            r_cnt <= w_short ? '0 : CNT_W'(1);
            r_run <= !w_short;
        end else if (r_run) begin
            if (w_last) begin
                r_cnt <= '0;
                r_run <= 1'b0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/note_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : note_sequencer
// Description : Plays a captured 40-bit song word note by note into the PWM
//               tone generator. Optional macro NOTE_SEQ_LOOP_EN loops the song.
// Revision    : 1.0 - initial release
// ============================================================================
module note_sequencer
    import music_pkg::*;
#(
    parameter int NUM_NOTES  = 10,
    parameter int NOTE_W     = 4,
    parameter int NOTE_TICKS = 2_000_000,
    parameter int GAP_TICKS  = 200_000,
    parameter int HP_W       = 16
) (
    input  logic                        clk,
    input  logic                        nreset,
    input  logic                        ce,
    input  logic [NUM_NOTES*NOTE_W-1:0] song_word,
    output logic [HP_W-1:0]             tone_half_period,
    output logic                        tone_en,
    output logic                        making_music,
    output logic [3:0]                  note_idx,
    output logic                        song_done
);

`ifdef NOTE_SEQ_LOOP_EN
    localparam bit c_loop_en = 1'b1;
`else
    localparam bit c_loop_en = 1'b0;
`endif

    seq_state_t                  r_state;
    logic                        r_ce_q;
    logic [NUM_NOTES*NOTE_W-1:0] r_song;
    logic                        r_first;
    logic                        r_tmr_start;
    logic [31:0]                 r_tmr_limit;
    logic [HP_W-1:0]             r_hp;
    logic                        r_tone_en;
    logic                        r_making_music;
    logic [3:0]                  r_note_idx;
    logic                        r_song_done;

    logic       w_ce_fall;
    logic       w_expire;
    logic       w_at_last;
    logic       w_advance;
    logic       w_wrap;
    logic       w_finish;
    logic [3:0] w_go_idx;
    logic [3:0] w_play_idx;
    note_code_t w_play_code;

    function automatic note_code_t f_slot(input logic [NUM_NOTES*NOTE_W-1:0] song,
                                          input logic [3:0] idx);
        note_code_t code;
        code = NOTE_REST;
        if (int'(idx) < NUM_NOTES)
            code = song[(NUM_NOTES - 1 - int'(idx)) * NOTE_W +: NOTE_W];
        return code;
    endfunction

    tick_timer #(
        .CNT_W (32)
    ) u_timer (
        .clk    (clk),
        .nreset (nreset),
        .start  (r_tmr_start),
        .limit  (r_tmr_limit),
        .expire (w_expire)
    );

    assign w_ce_fall = r_ce_q & ~ce;
    assign w_at_last = (r_note_idx == 4'(NUM_NOTES - 1));
    // A note is entered from the first PLAY cycle after LOAD, or straight out
    // of an expiring gap so that notes repeat every NOTE_TICKS+GAP_TICKS.
    assign w_advance = ((r_state == PLAY) && r_first) ||
                       ((r_state == GAP) && w_expire);

    always_comb begin
        w_go_idx = (r_state == GAP) ? r_note_idx + 4'd1 : r_note_idx;
        w_wrap   = 1'b0;
        w_finish = 1'b0;
        if ((r_state == GAP) && w_at_last) begin
            w_wrap   = c_loop_en;
            w_finish = !c_loop_en;
        end else if (f_slot(r_song, w_go_idx) == NOTE_END) begin
            // A terminator in slot 0 of a looping song plays as a rest.
            w_wrap   = c_loop_en && (w_go_idx != 4'd0);
            w_finish = !c_loop_en;
        end
        w_play_idx  = w_wrap ? 4'd0 : w_go_idx;
        w_play_code = f_slot(r_song, w_play_idx);
        if (w_play_code == NOTE_END)
            w_play_code = NOTE_REST;
    end

    always_ff @(posedge clk or posedge nreset) begin
        if (nreset) begin
            r_state        <= IDLE;
            r_ce_q         <= 1'b0;
            r_song         <= '0;
            r_first        <= 1'b0;
            r_tmr_start    <= 1'b0;
            r_tmr_limit    <= '0;
            r_hp           <= '0;
            r_tone_en      <= 1'b0;
            r_making_music <= 1'b0;
            r_note_idx     <= '0;
            r_song_done    <= 1'b0;
        end else begin
            r_ce_q      <= ce;
            r_tmr_start <= 1'b0;
            r_song_done <= 1'b0;
            if (w_ce_fall) begin
                r_song    <= song_word;
                r_state   <= LOAD;
                r_tone_en <= 1'b0;
                r_first   <= 1'b0;
            end else if (w_advance) begin
                r_first <= 1'b0;
                if (w_finish) begin
                    r_state        <= DONE;
                    r_song_done    <= 1'b1;
                    r_making_music <= 1'b0;
                    r_tone_en      <= 1'b0;
                    r_hp           <= '0;
                end else begin
                    r_state     <= PLAY;
                    r_note_idx  <= w_play_idx;
                    r_tone_en   <= (w_play_code != NOTE_REST);
                    r_hp        <= HP_W'(HP_TABLE[w_play_code]);
                    r_tmr_start <= 1'b1;
                    r_tmr_limit <= 32'(NOTE_TICKS);
                    r_song_done <= w_wrap;
                end
            end else begin
                case (r_state)
                    LOAD: begin
                        r_note_idx     <= '0;
                        r_making_music <= 1'b1;
                        r_first        <= 1'b1;
                        r_state        <= PLAY;
                    end
                    PLAY: begin
                        if (w_expire) begin
                            r_state     <= GAP;
                            r_tone_en   <= 1'b0;
                            r_tmr_start <= 1'b1;
                            r_tmr_limit <= 32'(GAP_TICKS);
                        end
                    end
                    DONE:    r_state <= IDLE;
                    default: ;
                endcase
            end
        end
    end

    assign tone_half_period = r_hp;
    assign tone_en          = r_tone_en;
    assign making_music     = r_making_music;
    assign note_idx         = r_note_idx;
    assign song_done        = r_song_done;

endmodule
`default_nettype wire

// File: tb/tb_note_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_note_sequencer
// Description : Self-checking bench for note_sequencer (NOTE_TICKS=20,
//               GAP_TICKS=4); covers NOTE_SEQ_LOOP_EN when that macro is set.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_note_sequencer;

    localparam int NT  = 20;
    localparam int GT  = 4;
    localparam int PER = NT + GT;

    logic        clk = 1'b0;
    logic        nreset = 1'b1;
    logic        ce = 1'b0;
    logic [39:0] song_word = '0;
    logic [15:0] tone_half_period;
    logic        tone_en;
    logic        making_music;
    logic [3:0]  note_idx;
    logic        song_done;

    note_sequencer #(
        .NUM_NOTES  (10),
        .NOTE_W     (4),
        .NOTE_TICKS (NT),
        .GAP_TICKS  (GT),
        .HP_W       (16)
    ) dut (
        .clk              (clk),
        .nreset           (nreset),
        .ce               (ce),
        .song_word        (song_word),
        .tone_half_period (tone_half_period),
        .tone_en          (tone_en),
        .making_music     (making_music),
        .note_idx         (note_idx),
        .song_done        (song_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [15:0] ref_hp [16] = '{
        16'd0,     16'd65535, 16'd65535, 16'd65535,
        16'd64282, 16'd60674, 16'd57269, 16'd54054,
        16'd51021, 16'd48157, 16'd45454, 16'd42903,
        16'd40495, 16'd38222, 16'd36077, 16'd0
    };

    typedef struct {
        int          cyc;
        logic        en;
        logic [15:0] hp;
        logic [3:0]  idx;
        logic        mm;
        logic        done;
        bit          chk_hp;
        bit          chk_idx;
        bit          chk_mm;
    } exp_t;

    typedef struct {
        logic [39:0] word;
        int          end_slot;
        int          snd_slot;
        logic [15:0] snd_hp;
    } vec_t;

    exp_t sb[$];
    exp_t e;
    int   checks = 0;
    int   failures = 0;
    int   done_pulses = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, req);
        end
    endtask

    function automatic exp_t mk(input int c, input logic en, input logic [15:0] hp,
                                input logic [3:0] idx, input logic mm, input logic done,
                                input bit ch, input bit ci, input bit cm);
        exp_t x;
        x.cyc = c; x.en = en; x.hp = hp; x.idx = idx; x.mm = mm; x.done = done;
        x.chk_hp = ch; x.chk_idx = ci; x.chk_mm = cm;
        return x;
    endfunction

    // Scoreboard: expected outputs per cycle, compared on the falling edge.
    always @(negedge clk) begin
        if (song_done === 1'b1) done_pulses++;
        while (sb.size() > 0 && sb[0].cyc < cyc) begin
            checks++;
            failures++;
            $display("FAIL sb_missed actual_cyc=%0d required_cyc=%0d", cyc, sb[0].cyc);
            void'(sb.pop_front());
        end
        if (sb.size() > 0 && sb[0].cyc == cyc) begin
            e = sb.pop_front();
            check("tone_en", tone_en, e.en);
            check("song_done", song_done, e.done);
            if (e.chk_mm)  check("making_music", making_music, e.mm);
            if (e.chk_hp)  check("tone_half_period", tone_half_period, e.hp);
            if (e.chk_idx) check("note_idx", note_idx, e.idx);
        end
    end

    task automatic push_head(input int k);
        sb.push_back(mk(k + 1, 1'b0, 16'd0, 4'd0, 1'b0, 1'b0, 0, 0, 0));
        sb.push_back(mk(k + 2, 1'b0, 16'd0, 4'd0, 1'b1, 1'b0, 0, 1, 1));
    endtask

    task automatic push_song(input int k, input logic [39:0] w);
        int         endslot;
        logic [3:0] code;
        int         dc;
        push_head(k);
        endslot = 10;
        for (int i = 0; i < 10; i++) begin
            code = w[(9 - i) * 4 +: 4];
            if (code == 4'hF) begin
                endslot = i;
                break;
            end
            for (int t = 0; t < PER; t++)
                sb.push_back(mk(k + 3 + PER * i + t, (t < NT) && (code != 4'h0),
                                ref_hp[code], 4'(i), 1'b1, 1'b0, 1, 1, 1));
        end
        dc = k + 3 + PER * endslot;
        sb.push_back(mk(dc, 1'b0, 16'd0, 4'd0, 1'b0, 1'b1, 1, 0, 1));
        sb.push_back(mk(dc + 1, 1'b0, 16'd0, 4'd0, 1'b0, 1'b0, 1, 0, 1));
    endtask

    task automatic start_song(input logic [39:0] w, output int k);
        @(posedge clk); #1;
        ce = 1'b1;
        song_word = w;
        @(posedge clk); #1;
        ce = 1'b0;
        k = cyc;
    endtask

    task automatic wait_done(output int got);
        got = -1;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            if (song_done === 1'b1) begin
                got = cyc;
                break;
            end
        end
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic check_idle(input string name, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check(name, {tone_en, making_music, song_done, note_idx, tone_half_period}, 32'd0);
        end
    endtask

    vec_t vecs[4];
    int   k;
    int   k2;
    int   got;
    int   pulses0;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_tone_en", tone_en, 1'b0);
        check("rst_making_music", making_music, 1'b0);
        check("rst_hp", tone_half_period, 16'd0);
        check("rst_note_idx", note_idx, 4'd0);
        check("rst_song_done", song_done, 1'b0);
        nreset = 1'b0;
        check_idle("idle_after_reset", 100);

        // ce held high never loads a song.
        ce = 1'b1;
        song_word = 40'h0123456789;
        check_idle("idle_ce_high", 30);

`ifdef NOTE_SEQ_LOOP_EN
        pulses0 = done_pulses;
        start_song(40'h1F00000000, k);
        push_head(k);
        for (int j = 0; j < 4; j++)
            for (int t = 0; t < PER; t++)
                sb.push_back(mk(k + 3 + PER * j + t, t < NT, 16'd65535, 4'd0, 1'b1,
                                (t == 0) && (j > 0), 1, 1, 1));
        wait_until(k + 3 + PER * 4 - 1);
        check("loop_done_pulses", done_pulses - pulses0, 3);
        check("loop_sb_drained", sb.size(), 0);
`else
        vecs[0] = '{40'h0123456789, 10, 1, 16'd65535};
        vecs[1] = '{40'h5AF3333333, 2, 0, 16'd60674};
        vecs[2] = '{40'hF123456789, 0, -1, 16'd0};
        vecs[3] = '{40'hA00000000C, 10, 0, 16'd45454};

        for (int v = 0; v < 4; v++) begin
            start_song(vecs[v].word, k);
            push_song(k, vecs[v].word);
            if (vecs[v].snd_slot >= 0) begin
                wait_until(k + 3 + PER * vecs[v].snd_slot + 2);
                check("first_tone_hp", tone_half_period, vecs[v].snd_hp);
                check("first_tone_en", tone_en, 1'b1);
            end
            wait_done(got);
            check("done_cycle", got, k + 3 + PER * vecs[v].end_slot);
            repeat (4) @(negedge clk);
            check("sb_drained", sb.size(), 0);
        end

        // Reload in the middle of note 4.
        start_song(40'h0123456789, k);
        push_song(k, 40'h0123456789);
        wait_until(k + 3 + PER * 4 + 5);
        check("reload_pre_idx", note_idx, 4'd4);
        pulses0 = done_pulses;
        start_song(40'hAAAAAAAAAA, k2);
        for (int i = sb.size() - 1; i >= 0; i--)
            if (sb[i].cyc > k2) sb.delete(i);
        push_song(k2, 40'hAAAAAAAAAA);
        wait_done(got);
        check("reload_done_cycle", got, k2 + 3 + PER * 10);
        repeat (4) @(negedge clk);
        check("reload_single_done", done_pulses - pulses0, 1);
        check("reload_sb_drained", sb.size(), 0);

        // Reset during note 2.
        start_song(40'h0123456789, k);
        push_song(k, 40'h0123456789);
        wait_until(k + 3 + PER * 2 + 5);
        check("pre_reset_tone_en", tone_en, 1'b1);
        sb.delete();
        #2 nreset = 1'b1;
        #1;
        check("async_rst_tone_en", tone_en, 1'b0);
        check("async_rst_making_music", making_music, 1'b0);
        check("async_rst_hp", tone_half_period, 16'd0);
        @(posedge clk);
        @(posedge clk); #1;
        nreset = 1'b0;
        check_idle("idle_after_midsong_reset", 60);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
